bloom_filter_loader: RTL and testbench
======================================

# bloom_filter_loader

Write-side engine for the firewall's 1024-bit Bloom filter. It accepts flow keys (32-bit IP/protocol word, source port, destination port) over a valid/ready handshake and computes the same 6-round hash the lookup path uses. It then sets filter bit hash[9:0] and exports the whole filter vector to the lookup side. It also performs a multi-cycle sweep clear on request, and keeps a live count of set bits.

## Interface
- FILTER_BITS, 1024, filter size; must be 1024 (index is hash[9:0])
- CLR_WIDTH, 32, bits zeroed per clear cycle; must divide FILTER_BITS
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- ins_valid  in  1  insert request valid
- ins_ready  out  1  high when an insert can be accepted
- ins_k0  in  32  key word 0 (IP/protocol low 32 bits)
- ins_k1  in  16  key word 1 (source port)
- ins_k2  in  16  key word 2 (destination port)
- clr_req  in  1  clear request; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when an insert or clear completes
- done_index  out  10  bit index written by the last insert; held until the next insert
- new_bit  out  1  with done after an insert: 1 if the bit was previously 0; 0 after a clear
- filter_bits  out  FILTER_BITS  current filter contents, registered
- set_count  out  11  number of 1 bits in filter_bits (0..1024)

## Operation
- States: IDLE, H1–H6, SET, CLEAR.
- ins_ready = (state==IDLE) && !clr_req. Clear has priority when clr_req and ins_valid are both high.
- Insert accept (ins_valid && ins_ready), registered at the accept edge:
  - a0 = 0xdeadbef8 + k0
  - b0 = 0xdeadbef1 + zext(k1)
  - c0 = 0xdeadbef8 + zext(k2[7:0])
- Hash rounds, one per state; all arithmetic mod 2^32, rol = rotate left:
  - H1: c1 = (c0^b0) − rol(b0,14)
  - H2: a1 = (a0^c1) − rol(c1,11)
  - H3: b1 = (b0^a1) − rol(a1,25)
  - H4: a2 = (a1^c1) − rol(c1,4)
  - H5: b2 = (b1^a2) − rol(a2,14)
  - H6: h = (c1^b2) − rol(b2,24)
- SET state:
  - filter_bits[h[9:0]] ← 1
  - done_index ← h[9:0]
  - new_bit ← ~old bit
  - set_count += new_bit
  - done ← 1, state ← IDLE
- Duplicate key or colliding index: the bit stays 1, new_bit=0, set_count unchanged.
- Clear (clr_req high in IDLE): go to CLEAR with word pointer 0.
  - Each CLEAR cycle zeroes bits [ptr*CLR_WIDTH +: CLR_WIDTH] and increments ptr.
  - After word FILTER_BITS/CLR_WIDTH−1: set_count ← 0, done ← 1, new_bit ← 0, state ← IDLE.
  - During the sweep, set_count holds its pre-clear value.
- Inputs are ignored outside IDLE. ins_k* need be stable only in the accept cycle.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, filter_bits=0, set_count=0, done=0, new_bit=0, done_index=0, busy=0. ins_ready follows its IDLE formula.
- Reset mid-insert or mid-clear aborts immediately; the filter is fully zeroed.
- Insert latency:
  - Accept edge at end of cycle 0; H1–H6 occupy cycles 1–6; SET is cycle 7.
  - In cycle 8: done=1, filter_bits/set_count updated, ins_ready high again.
  - Maximum throughput is 1 insert per 8 cycles; back-to-back accept in cycle 8 is legal.
- Clear latency: accept at cycle 0, 32 CLEAR cycles (default parameters), done in cycle 33.
- done is high for exactly one cycle. busy is low in the done cycle.

## Test plan
- Reset → all outputs 0, ins_ready=1. Assert reset=0 mid-H3 → filter_bits=0 and state IDLE in the same cycle.
- Insert k0=0, k1=0, k2=0:
  - done exactly 8 cycles after accept.
  - done_index = golden-model h[9:0]; that bit alone set; set_count=1; new_bit=1.
- Repeat the same key → identical done_index, new_bit=0, set_count stays 1.
- Key width check:
  - Insert k2=0x12FF, then k2=0x00FF with the other keys equal → same index (only k2[7:0] used).
  - Insert k0=0xFFFFFFFF → golden index matches; exercises 32-bit wrap in a0.
- 20 back-to-back random inserts with ins_valid held high → 8-cycle spacing; set_count equals popcount(filter_bits) after each done.
- clr_req and ins_valid both high in IDLE → ins_ready=0 and the insert is not accepted.
  - done 33 cycles later; filter_bits=0, set_count=0.
  - The held insert is accepted in the following cycle.

Source files
------------

// File: rtl/bloom_filter_loader.sv
// Write-side engine for the 1024-bit firewall Bloom filter: hashes flow keys over six
// rounds, sets the indexed bit, keeps a live popcount and sweep-clears on request.
module bloom_filter_loader #(
   parameter int FILTER_BITS = 1024,
   parameter int CLR_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ins_valid,
   output logic                   ins_ready,
   input  logic [31:0]            ins_k0,
   input  logic [15:0]            ins_k1,
   input  logic [15:0]            ins_k2,
   input  logic                   clr_req,
   output logic                   busy,
   output logic                   done,
   output logic [9:0]             done_index,
   output logic                   new_bit,
   output logic [FILTER_BITS-1:0] filter_bits,
   output logic [10:0]            set_count
);

   localparam int NWORDS = FILTER_BITS / CLR_WIDTH;
   localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_H1, S_H2, S_H3, S_H4, S_H5, S_H6, S_SET, S_CLEAR
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      ha, hb, hc;
   logic [31:0]      round;
   logic [PTR_W-1:0] ptr;
   logic             accept_ins, accept_clr, last_word;
   logic [9:0]       set_idx;
   logic             bit_new;
   logic             unused_k2;

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Only the low byte of the destination port feeds the hash.
   assign unused_k2  = ^ins_k2[15:8];

   assign ins_ready  = (state == S_IDLE) && !clr_req;
   assign busy       = (state != S_IDLE);
   assign accept_clr = (state == S_IDLE) && clr_req;
   assign accept_ins = ins_valid && ins_ready;
   assign last_word  = (ptr == PTR_W'(NWORDS - 1));
   assign set_idx    = hc[9:0];
   assign bit_new    = ~filter_bits[set_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept_clr)      state_nxt = S_CLEAR;
            else if (accept_ins) state_nxt = S_H1;
         end
         S_H1:    state_nxt = S_H2;
         S_H2:    state_nxt = S_H3;
         S_H3:    state_nxt = S_H4;
         S_H4:    state_nxt = S_H5;
         S_H5:    state_nxt = S_H6;
         S_H6:    state_nxt = S_SET;
         S_SET:   state_nxt = S_IDLE;
         S_CLEAR: if (last_word) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One mixing round per state; the result replaces one of a/b/c in place.
   always_comb begin
      round = '0;
      unique case (state)
         S_H1:    round = (hc ^ hb) - rol(hb, 14);
         S_H2:    round = (ha ^ hc) - rol(hc, 11);
         S_H3:    round = (hb ^ ha) - rol(ha, 25);
         S_H4:    round = (ha ^ hc) - rol(hc, 4);
         S_H5:    round = (hb ^ ha) - rol(ha, 14);
         S_H6:    round = (hc ^ hb) - rol(hb, 24);
         default: round = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ha <= '0;
         hb <= '0;
         hc <= '0;
      end else if (accept_ins) begin
         ha <= 32'hdeadbef8 + ins_k0;
         hb <= 32'hdeadbef1 + {16'h0000, ins_k1};
         hc <= 32'hdeadbef8 + {24'h000000, ins_k2[7:0]};
      end else begin
         unique case (state)
            S_H1, S_H6: hc <= round;
            S_H2, S_H4: ha <= round;
            S_H3, S_H5: hb <= round;
            default: ;
         endcase
      end
   end

   // set_count deliberately holds its pre-clear value until the sweep finishes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filter_bits <= '0;
         set_count   <= '0;
         done        <= 1'b0;
         new_bit     <= 1'b0;
         done_index  <= '0;
         ptr         <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: if (accept_clr) ptr <= '0;
            S_SET: begin
               filter_bits[set_idx] <= 1'b1;
               done_index           <= set_idx;
               new_bit              <= bit_new;
               set_count            <= set_count + {10'd0, bit_new};
               done                 <= 1'b1;
            end
            S_CLEAR: begin
               filter_bits[int'(ptr) * CLR_WIDTH +: CLR_WIDTH] <= '0;
               ptr <= ptr + PTR_W'(1);
               if (last_word) begin
                  set_count <= '0;
                  new_bit   <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bloom_filter_loader.sv
// Randomized + directed bench for bloom_filter_loader against a countdown-based
// transaction model that applies each insert/clear when its latency elapses.
module tb_bloom_filter_loader;

   localparam int FB = 1024;
   localparam int CW = 32;
   localparam int NW = FB / CW;

   logic          clk = 1'b0;
   logic          reset;
   logic          ins_valid, clr_req;
   logic [31:0]   ins_k0;
   logic [15:0]   ins_k1, ins_k2;
   logic          ins_ready, busy, done, new_bit;
   logic [9:0]    done_index;
   logic [FB-1:0] filter_bits;
   logic [10:0]   set_count;

   int n_cmp = 0;
   int n_bad = 0;

   bloom_filter_loader #(.FILTER_BITS(FB), .CLR_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins_ready(ins_ready),
      .ins_k0(ins_k0), .ins_k1(ins_k1), .ins_k2(ins_k2), .clr_req(clr_req),
      .busy(busy), .done(done), .done_index(done_index), .new_bit(new_bit),
      .filter_bits(filter_bits), .set_count(set_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [9:0] golden_hash(input logic [31:0] k0, input logic [15:0] k1,
                                              input logic [15:0] k2);
      logic [31:0] a0, b0, c0, c1, a1, b1, a2, b2, h;
      a0 = 32'hdeadbef8 + k0;
      b0 = 32'hdeadbef1 + {16'h0, k1};
      c0 = 32'hdeadbef8 + {24'h0, k2[7:0]};
      c1 = (c0 ^ b0) - rol(b0, 14);
      a1 = (a0 ^ c1) - rol(c1, 11);
      b1 = (b0 ^ a1) - rol(a1, 25);
      a2 = (a1 ^ c1) - rol(c1, 4);
      b2 = (b1 ^ a2) - rol(a2, 14);
      h  = (c1 ^ b2) - rol(b2, 24);
      return h[9:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: rem counts edges until the pending operation lands.
   logic [FB-1:0] m_filt;
   int            m_cnt, rem, acc_cyc, cyc = 0;
   logic          m_done, m_new, op_clr, acc_now;
   logic [9:0]    m_idx, m_h;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_filt = '0; m_cnt = 0; m_done = 0; m_new = 0; m_idx = '0;
         rem = 0; acc_now = 0; op_clr = 0; m_h = '0;
      end else begin
         acc_now = 0;
         m_done  = 0;
         if (rem > 0) begin
            if (op_clr) m_filt[(NW - rem) * CW +: CW] = '0;
            rem--;
            if (rem == 0) begin
               m_done = 1;
               if (op_clr) begin
                  m_cnt = 0;
                  m_new = 0;
               end else begin
                  m_new       = !m_filt[m_h];
                  m_filt[m_h] = 1'b1;
                  m_idx       = m_h;
                  m_cnt       = $countones(m_filt);
               end
            end
         end else if (clr_req) begin
            op_clr = 1; rem = NW; acc_cyc = cyc;
         end else if (ins_valid) begin
            op_clr = 0; rem = 7; acc_cyc = cyc; acc_now = 1;
            m_h = golden_hash(ins_k0, ins_k1, ins_k2);
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("busy", busy, rem != 0);
         chk("ins_ready", ins_ready, (rem == 0) && !clr_req);
         chk("done", done, m_done);
         chk("set_count", set_count, m_cnt);
         chk("done_index", done_index, m_idx);
         chk("new_bit", new_bit, m_new);
         n_cmp++;
         if (filter_bits !== m_filt) begin
            n_bad++;
            $display("FAIL filter_bits: got popcount %0d expected popcount %0d at %0t",
                     $countones(filter_bits), $countones(m_filt), $time);
         end
         if (done) begin
            chk("latency", cyc - acc_cyc, op_clr ? NW + 1 : 8);
            chk("popcount", $countones(filter_bits), set_count);
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (rem != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("idle_timeout", t >= 200, 0);
   endtask

   task automatic insert(input logic [31:0] k0, input logic [15:0] k1, input logic [15:0] k2);
      wait_idle();
      ins_valid = 1; ins_k0 = k0; ins_k1 = k1; ins_k2 = k2;
      @(posedge clk); #1;
      ins_valid = 0;
      wait_idle();
   endtask

   initial begin
      int cnt, t;
      reset = 0; ins_valid = 0; clr_req = 0; ins_k0 = '0; ins_k1 = '0; ins_k2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_filter", $countones(filter_bits), 0);
      chk("rst_count", set_count, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_new", new_bit, 0);
      chk("rst_index", done_index, 0);
      chk("rst_ready", ins_ready, 1);
      reset = 1;
      @(posedge clk); #1;

      insert(32'h0, 16'h0, 16'h0);
      chk("first_count", set_count, 1);
      chk("first_new", new_bit, 1);
      chk("first_done", done, 1);
      chk("first_index", done_index, golden_hash(32'h0, 16'h0, 16'h0));
      chk("first_onebit", $countones(filter_bits), 1);

      insert(32'h0, 16'h0, 16'h0);
      chk("dup_new", new_bit, 0);
      chk("dup_count", set_count, 1);
      chk("dup_index", done_index, golden_hash(32'h0, 16'h0, 16'h0));

      insert(32'h1234, 16'h0055, 16'h12FF);
      insert(32'h1234, 16'h0055, 16'h00FF);
      chk("k2_low_new", new_bit, 0);
      chk("k2_low_index", done_index, golden_hash(32'h1234, 16'h0055, 16'h12FF));

      insert(32'hFFFFFFFF, 16'hABCD, 16'h0042);
      chk("wrap_index", done_index, golden_hash(32'hFFFFFFFF, 16'hABCD, 16'h0042));

      // Abort mid-hash with a populated filter.
      ins_valid = 1; ins_k0 = 32'h0BADF00D; ins_k1 = 16'h1111; ins_k2 = 16'h2222;
      @(posedge clk); #1;
      ins_valid = 0;
      repeat (2) @(posedge clk);
      #2 reset = 0;
      #1;
      chk("abort_filter", $countones(filter_bits), 0);
      chk("abort_busy", busy, 0);
      chk("abort_count", set_count, 0);
      chk("abort_ready", ins_ready, 1);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;

      cnt = 0; t = 0;
      ins_valid = 1; ins_k0 = $urandom; ins_k1 = 16'($urandom); ins_k2 = 16'($urandom);
      while (cnt < 20 && t < 400) begin
         @(posedge clk); #1;
         t++;
         if (acc_now) begin
            cnt++;
            ins_k0 = $urandom; ins_k1 = 16'($urandom); ins_k2 = 16'($urandom);
            if (cnt == 20) ins_valid = 0;
         end
      end
      ins_valid = 0;
      chk("b2b_count", cnt, 20);
      wait_idle();

      clr_req = 1; ins_valid = 1;
      ins_k0 = $urandom; ins_k1 = 16'($urandom); ins_k2 = 16'($urandom);
      #2;
      chk("clr_prio_ready", ins_ready, 0);
      @(posedge clk); #1;
      clr_req = 0;
      chk("clr_busy", busy, 1);
      wait_idle();
      chk("clr_done", done, 1);
      chk("clr_count", set_count, 0);
      chk("clr_filter", $countones(filter_bits), 0);
      @(posedge clk); #1;
      ins_valid = 0;
      chk("held_accept", busy, 1);
      wait_idle();
      chk("held_count", set_count, 1);
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
